// File: rtl/sfp_pkg.sv
// Shared constants and types for the sfp multiply-add arbiter slice.
// sfp word layout: {sign, exp[7:0], frac[16:0]}.
package sfp_pkg;

  localparam int SFP_W       = 26;
  localparam int SFP_EXP_MSB = 24;
  localparam int SFP_EXP_LSB = 17;
  localparam int SFP_FRA_W   = 17;
  localparam int DEF_MU_LAT  = 7;
  localparam int TAG_IDW     = 3;
  localparam int STAT_W      = 16;

  // The id field is sized for the largest supported NREQ (8).
  typedef struct packed {
    logic               vld;
    logic [TAG_IDW-1:0] id;
  } tag_t;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] cnt);
    if (cnt == {STAT_W{1'b1}}) begin
      return cnt;
    end else begin
      return cnt + {{(STAT_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/sfp_rr_arb.sv
// Round-robin picker: selects the first requester above ptr, wrapping.
// Purely combinational; the pointer register lives in the parent.
module sfp_rr_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  id
);

  logic [IDW:0]   sum_s;
  logic [IDW-1:0] idx_s;
  logic           found_s;

  // Scan ptr+1 .. ptr+NREQ modulo NREQ and take the first set request.
  always_comb begin
    gnt     = '0;
    id      = '0;
    found_s = 1'b0;
    sum_s   = '0;
    idx_s   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      sum_s = {1'b0, ptr} + (IDW+1)'(k);
      if (sum_s >= (IDW+1)'(NREQ)) begin
        idx_s = IDW'(sum_s - (IDW+1)'(NREQ));
      end else begin
        idx_s = sum_s[IDW-1:0];
      end
      if (!found_s && req[idx_s]) begin
        found_s    = 1'b1;
        gnt[idx_s] = 1'b1;
        id         = idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/sfp_mac_arbiter.sv
// Round-robin sharing of one pipelined sfp A*B+C engine, with a tag pipe routing results back.
// Optional per-requester grant counters when SFP_ARB_STAT_EN is defined.
module sfp_mac_arbiter
  import sfp_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int MU_LAT = DEF_MU_LAT,
  parameter int IDW    = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_en,
  input  logic [NREQ-1:0]        i_req,
  input  logic [NREQ*SFP_W-1:0]  i_da,
  input  logic [NREQ*SFP_W-1:0]  i_db,
  input  logic [NREQ*SFP_W-1:0]  i_dc,
  output logic [NREQ-1:0]        o_gnt,
  output logic                   o_mu_req,
  output logic [SFP_W-1:0]       o_mu_da,
  output logic [SFP_W-1:0]       o_mu_db,
  output logic [SFP_W-1:0]       o_mu_dc,
  input  logic                   i_mu_vld,
  input  logic [SFP_W-1:0]       i_mu_do,
  output logic [NREQ-1:0]        o_rsp_vld,
  output logic [SFP_W-1:0]       o_rsp_do,
  output logic                   o_busy,
  output logic                   o_err,
  output logic [NREQ*STAT_W-1:0] o_stat_cnt
);

  logic [IDW-1:0]  ptr_r;
  logic [IDW-1:0]  iss_id_r;
  logic [IDW-1:0]  win_id_s;
  logic [NREQ-1:0] win_oh_s;
  logic [NREQ-1:0] gnt_s;
  logic [NREQ-1:0] rsp_oh_s;
  tag_t            tag_r [MU_LAT];
  tag_t            tag_out_s;
  logic            busy_s;

  sfp_rr_arb #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_arb (
    .req (i_req),
    .ptr (ptr_r),
    .gnt (win_oh_s),
    .id  (win_id_s)
  );

  // Grant only while enabled and out of reset, so requests are ignored while i_en is low.
  always_comb begin
    if (i_en && (|i_req) && !i_rst) begin
      gnt_s = win_oh_s;
    end else begin
      gnt_s = '0;
    end
  end

  assign o_gnt = gnt_s;

  // Issue stage: register the winner's operands and advance the pointer on each grant.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr_r    <= IDW'(NREQ-1);
      iss_id_r <= '0;
      o_mu_req <= 1'b0;
      o_mu_da  <= '0;
      o_mu_db  <= '0;
      o_mu_dc  <= '0;
    end else begin
      o_mu_req <= |gnt_s;
      if (|gnt_s) begin
        ptr_r    <= win_id_s;
        iss_id_r <= win_id_s;
        o_mu_da  <= i_da[SFP_W*int'(win_id_s) +: SFP_W];
        o_mu_db  <= i_db[SFP_W*int'(win_id_s) +: SFP_W];
        o_mu_dc  <= i_dc[SFP_W*int'(win_id_s) +: SFP_W];
      end else begin
        ptr_r    <= ptr_r;
        iss_id_r <= iss_id_r;
        o_mu_da  <= o_mu_da;
        o_mu_db  <= o_mu_db;
        o_mu_dc  <= o_mu_dc;
      end
    end
  end

  // Tag pipe: MU_LAT stages so the tag leaves in the same cycle as the engine's valid.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int s = 0; s < MU_LAT; s++) begin
        tag_r[s] <= '0;
      end
    end else begin
      tag_r[0].vld <= o_mu_req;
      tag_r[0].id  <= TAG_IDW'(iss_id_r);
      for (int s = 1; s < MU_LAT; s++) begin
        tag_r[s] <= tag_r[s-1];
      end
    end
  end

  assign tag_out_s = tag_r[MU_LAT-1];

  // Busy covers the issue register plus every occupied tag stage.
  always_comb begin
    busy_s = o_mu_req;
    for (int s = 0; s < MU_LAT; s++) begin
      busy_s = busy_s | tag_r[s].vld;
    end
  end

  assign o_busy = busy_s;

  // Decode the emerging tag id into the response one-hot.
  always_comb begin
    rsp_oh_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      rsp_oh_s[i] = (tag_out_s.id == TAG_IDW'(i));
    end
  end

  // Return stage: route matched results; any valid/tag disagreement sets the sticky error.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rsp_vld <= '0;
      o_rsp_do  <= '0;
      o_err     <= 1'b0;
    end else begin
      if (i_mu_vld && tag_out_s.vld) begin
        o_rsp_vld <= rsp_oh_s;
        o_rsp_do  <= i_mu_do;
      end else begin
        o_rsp_vld <= '0;
        o_rsp_do  <= o_rsp_do;
      end
      if (i_mu_vld != tag_out_s.vld) begin
        o_err <= 1'b1;
      end else begin
        o_err <= o_err;
      end
    end
  end

`ifdef SFP_ARB_STAT_EN
  logic [STAT_W-1:0] stat_r [NREQ];

  // Saturating grant counters, cleared only by reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NREQ; i++) begin
        stat_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (gnt_s[i]) begin
          stat_r[i] <= sat_inc(stat_r[i]);
        end else begin
          stat_r[i] <= stat_r[i];
        end
      end
    end
  end

  // Flatten the counters onto the stat bus.
  always_comb begin
    o_stat_cnt = '0;
    for (int i = 0; i < NREQ; i++) begin
      o_stat_cnt[STAT_W*i +: STAT_W] = stat_r[i];
    end
  end
`else
  assign o_stat_cnt = '0;
`endif

endmodule
